// File: rtl/fetch_unit_r32i.sv
// RV32I instruction fetch stage: owns the PC, issues word reads to instruction memory
// and buffers returned words in a 2-entry FIFO presented to the decoder.
module fetch_unit_r32i #(
    parameter int unsigned      dataW    = 32,
    parameter logic [dataW-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [dataW-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [dataW-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [dataW-1:0] redirect_pc,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic [dataW-1:0] rawIns,
    output logic [dataW-1:0] ins_pc
);

    localparam logic [0:0] StRun   = 1'b0;
    localparam logic [0:0] StFlush = 1'b1;

    logic             r_req_valid;
    logic [dataW-1:0] r_req_addr;
    logic             r_req_stale;
    logic [dataW-1:0] r_fetch_pc;
    logic [dataW-1:0] r_rsp_pc;
    logic [1:0]       r_outstanding;
    logic [1:0]       r_discard;
    logic [1:0]       r_count;
    logic [0:0]       r_state;
    logic [dataW-1:0] r_e0_data;
    logic [dataW-1:0] r_e0_pc;
    logic [dataW-1:0] r_e1_data;
    logic [dataW-1:0] r_e1_pc;

    logic             w_xfer;
    logic             w_pending;
    logic             w_drop;
    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic [1:0]       w_out_next;
    logic [1:0]       w_disc_next;
    logic [1:0]       w_count_next;
    logic [2:0]       w_occ;
    logic [0:0]       w_state_next;
    logic [dataW-1:0] w_fetch_pc_next;
    logic [dataW-1:0] w_redirect_pc;
    logic             w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    always_comb begin
        w_xfer          = r_req_valid & imem_req_ready;
        w_pending       = r_req_valid & ~imem_req_ready;
        w_drop          = imem_rsp_valid & (r_discard != 2'd0);
        w_pop           = (r_count != 2'd0) & ins_ready;
        w_push          = imem_rsp_valid & ~w_drop & ((r_count != 2'd2) | w_pop);
        w_out_next      = r_outstanding + {1'b0, w_xfer} - {1'b0, imem_rsp_valid};
        w_redirect_pc   = {redirect_pc[dataW-1:2], 2'b00};
        w_count_next    = r_count;
        w_disc_next     = r_discard;
        w_fetch_pc_next = r_fetch_pc;
        w_state_next    = r_state;
        if (redirect_valid) begin
            // A still-unaccepted request will complete later, so its response is dropped too.
            w_count_next    = 2'd0;
            w_disc_next     = w_out_next + {1'b0, w_pending};
            w_fetch_pc_next = w_redirect_pc;
            w_state_next    = (w_disc_next != 2'd0) ? StFlush : StRun;
        end else begin
            w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
            w_disc_next  = r_discard - {1'b0, w_drop};
            if (w_xfer && !r_req_stale) begin
                w_fetch_pc_next = r_fetch_pc + dataW'(4);
            end
            if (r_state == StFlush && w_disc_next == 2'd0) begin
                w_state_next = StRun;
            end
        end
        w_occ   = {1'b0, w_count_next} + {1'b0, w_out_next};
        w_issue = ~w_pending & (r_state == StRun) & ~redirect_valid & (w_occ < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid   <= 1'b0;
            r_req_addr    <= RESET_PC;
            r_req_stale   <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= 2'd0;
            r_discard     <= 2'd0;
            r_count       <= 2'd0;
            r_state       <= StRun;
            r_e0_data     <= '0;
            r_e0_pc       <= '0;
            r_e1_data     <= '0;
            r_e1_pc       <= '0;
        end else begin
            r_req_valid   <= w_pending | w_issue;
            if (!w_pending) begin
                r_req_addr <= w_fetch_pc_next;
            end
            // A request held across a redirect fetches an old address; it must not advance the PC.
            r_req_stale   <= redirect_valid ? w_pending : (r_req_stale & ~w_xfer);
            r_fetch_pc    <= w_fetch_pc_next;
            r_outstanding <= w_out_next;
            r_discard     <= w_disc_next;
            r_count       <= w_count_next;
            r_state       <= w_state_next;
            if (redirect_valid) begin
                r_rsp_pc <= w_redirect_pc;
            end else if (imem_rsp_valid && !w_drop) begin
                r_rsp_pc <= r_rsp_pc + dataW'(4);
            end
            if (!redirect_valid) begin
                if (w_pop) begin
                    r_e0_data <= r_e1_data;
                    r_e0_pc   <= r_e1_pc;
                end
                if (w_push) begin
                    if (r_count == 2'd0 || (r_count == 2'd1 && w_pop)) begin
                        r_e0_data <= imem_rsp_data;
                        r_e0_pc   <= r_rsp_pc;
                    end else begin
                        r_e1_data <= imem_rsp_data;
                        r_e1_pc   <= r_rsp_pc;
                    end
                end
            end
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_req_addr;
    assign ins_valid      = (r_count != 2'd0);
    assign rawIns         = r_e0_data;
    assign ins_pc         = r_e0_pc;

endmodule
